// File: rtl/rcp_reg_ring_master_pkg.sv
// Shared register-ring definitions: bus widths, the unclaimed-access marker
// and the ring master state encoding.
package rcp_reg_ring_master_pkg;

    localparam int UDP_REG_ADDR_WIDTH  = 23;
    localparam int CPCI_NF2_DATA_WIDTH = 32;

    // Read data reported for any access that no responder claimed.
    localparam logic [CPCI_NF2_DATA_WIDTH-1:0] REG_DEAD_BEEF = 32'hdead_beef;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } ring_state_e;

endpackage

// File: rtl/rcp_reg_ring_master.sv
// Register ring initiator/terminator: launches one host access onto the ring,
// collects it at the tail (or times out) and reports data/status to the host.
module rcp_reg_ring_master
    import rcp_reg_ring_master_pkg::*;
#(
    parameter int          UDP_REG_SRC_WIDTH = 2,
    parameter int unsigned SRC_ID            = 0,
    parameter int          TIMEOUT           = 255,
    parameter int          TO_WIDTH          = 8
) (
    input  logic                           clk,
    input  logic                           reset,

    input  logic                           core_reg_req,
    input  logic                           core_reg_rd_wr_L,
    input  logic [UDP_REG_ADDR_WIDTH-1:0]  core_reg_addr,
    input  logic [CPCI_NF2_DATA_WIDTH-1:0] core_reg_wr_data,
    output logic                           core_reg_busy,
    output logic                           core_reg_ack,
    output logic [CPCI_NF2_DATA_WIDTH-1:0] core_reg_rd_data,
    output logic                           core_reg_err,

    output logic                           reg_req_out,
    output logic                           reg_ack_out,
    output logic                           reg_rd_wr_L_out,
    output logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
    output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out,

    input  logic                           reg_req_in,
    input  logic                           reg_ack_in,
    input  logic                           reg_rd_wr_L_in,
    input  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
    input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in,

    output ring_state_e                    dbg_state_o
);

    localparam logic [UDP_REG_SRC_WIDTH-1:0] SRC_TAG = UDP_REG_SRC_WIDTH'(SRC_ID);
    localparam logic [TO_WIDTH-1:0]          TO_LAST = TO_WIDTH'(TIMEOUT - 1);

    ring_state_e state_q, state_d;
    logic [TO_WIDTH-1:0] cnt_q, cnt_d;

    logic                           rd_wr_l_q, rd_wr_l_d;
    logic [UDP_REG_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [CPCI_NF2_DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                           busy_q, busy_d;
    logic                           ack_q, ack_d;
    logic [CPCI_NF2_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                           err_q, err_d;

    logic                           head_req_q, head_req_d;
    logic                           head_rd_wr_l_q, head_rd_wr_l_d;
    logic [UDP_REG_ADDR_WIDTH-1:0]  head_addr_q, head_addr_d;
    logic [CPCI_NF2_DATA_WIDTH-1:0] head_data_q, head_data_d;
    logic [UDP_REG_SRC_WIDTH-1:0]   head_src_q, head_src_d;

    logic ret_valid;
    logic unused_tail;

    // Tail address/direction are not needed: only one access is ever in flight.
    assign unused_tail = ^{reg_rd_wr_L_in, reg_addr_in};
    assign ret_valid   = reg_req_in && (reg_src_in == SRC_TAG);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_wr_l_d = rd_wr_l_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        err_d     = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (core_reg_req) begin
                    rd_wr_l_d = core_reg_rd_wr_L;
                    addr_d    = core_reg_addr;
                    wdata_d   = core_reg_wr_data;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A return on the timeout boundary cycle still counts as a return.
                if (ret_valid) begin
                    rd_data_d = reg_ack_in ? reg_data_in : REG_DEAD_BEEF;
                    err_d     = !reg_ack_in;
                    state_d   = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    rd_data_d = REG_DEAD_BEEF;
                    err_d     = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d         = (state_d != ST_IDLE);
        ack_d          = (state_d == ST_DONE);
        head_req_d     = (state_d == ST_ISSUE);
        head_rd_wr_l_d = head_req_d ? rd_wr_l_d : 1'b0;
        head_addr_d    = head_req_d ? addr_d : '0;
        head_data_d    = (head_req_d && !rd_wr_l_d) ? wdata_d : '0;
        head_src_d     = head_req_d ? SRC_TAG : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            rd_wr_l_q      <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            busy_q         <= 1'b0;
            ack_q          <= 1'b0;
            rd_data_q      <= '0;
            err_q          <= 1'b0;
            head_req_q     <= 1'b0;
            head_rd_wr_l_q <= 1'b0;
            head_addr_q    <= '0;
            head_data_q    <= '0;
            head_src_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rd_wr_l_q      <= rd_wr_l_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            busy_q         <= busy_d;
            ack_q          <= ack_d;
            rd_data_q      <= rd_data_d;
            err_q          <= err_d;
            head_req_q     <= head_req_d;
            head_rd_wr_l_q <= head_rd_wr_l_d;
            head_addr_q    <= head_addr_d;
            head_data_q    <= head_data_d;
            head_src_q     <= head_src_d;
        end
    end

    assign core_reg_busy    = busy_q;
    assign core_reg_ack     = ack_q;
    assign core_reg_rd_data = rd_data_q;
    assign core_reg_err     = err_q;

    // The master never claims its own request, so the head ack is always 0.
    assign reg_ack_out      = 1'b0;
    assign reg_req_out      = head_req_q;
    assign reg_rd_wr_L_out  = head_rd_wr_l_q;
    assign reg_addr_out     = head_addr_q;
    assign reg_data_out     = head_data_q;
    assign reg_src_out      = head_src_q;

    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_rcp_reg_ring_master.sv
// Directed plus randomized bench for rcp_reg_ring_master; the bench itself acts
// as the ring (RCP register block responder plus loopback of unmapped tags).
module tb_rcp_reg_ring_master;
  import rcp_reg_ring_master_pkg::*;

  localparam int SW      = 2;
  localparam int SRC     = 1;
  localparam int TOUT    = 16;
  localparam int AW      = UDP_REG_ADDR_WIDTH;
  localparam int DW      = CPCI_NF2_DATA_WIDTH;
  localparam logic [14:0] RCP_TAG = 15'h0123;
  localparam logic [DW-1:0] DEAD  = 32'hdead_beef;

  logic clk = 1'b0;
  logic reset;

  logic          core_reg_req, core_reg_rd_wr_L;
  logic [AW-1:0] core_reg_addr;
  logic [DW-1:0] core_reg_wr_data;
  logic          core_reg_busy, core_reg_ack, core_reg_err;
  logic [DW-1:0] core_reg_rd_data;

  logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [DW-1:0] reg_data_out;
  logic [SW-1:0] reg_src_out;

  logic          reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [AW-1:0] reg_addr_in;
  logic [DW-1:0] reg_data_in;
  logic [SW-1:0] reg_src_in;

  ring_state_e dbg_state;

  int total = 0;
  int bad   = 0;

  // RCP register block contents as seen by the responder model
  logic [DW-1:0] regs [logic [AW-1:0]];

  rcp_reg_ring_master #(
    .UDP_REG_SRC_WIDTH(SW), .SRC_ID(SRC), .TIMEOUT(TOUT), .TO_WIDTH(5)
  ) dut (
    .clk(clk), .reset(reset),
    .core_reg_req(core_reg_req), .core_reg_rd_wr_L(core_reg_rd_wr_L),
    .core_reg_addr(core_reg_addr), .core_reg_wr_data(core_reg_wr_data),
    .core_reg_busy(core_reg_busy), .core_reg_ack(core_reg_ack),
    .core_reg_rd_data(core_reg_rd_data), .core_reg_err(core_reg_err),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out),
    .reg_rd_wr_L_out(reg_rd_wr_L_out), .reg_addr_out(reg_addr_out),
    .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in),
    .reg_rd_wr_L_in(reg_rd_wr_L_in), .reg_addr_in(reg_addr_in),
    .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] head_bus();
    return {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out};
  endfunction

  // driver tasks
  task automatic clear_tail();
    reg_req_in     = 1'b0;
    reg_ack_in     = 1'b0;
    reg_rd_wr_L_in = 1'b0;
    reg_addr_in    = '0;
    reg_data_in    = '0;
    reg_src_in     = '0;
  endtask

  task automatic drive_ret(input logic [SW-1:0] src, input logic ack, input logic [DW-1:0] data,
                           input logic [AW-1:0] addr, input logic rdwr);
    reg_req_in     = 1'b1;
    reg_ack_in     = ack;
    reg_rd_wr_L_in = rdwr;
    reg_addr_in    = addr;
    reg_data_in    = data;
    reg_src_in     = src;
  endtask

  // Ring behaviour: the RCP block claims its tag; everything else loops back unclaimed.
  task automatic ring_model(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            output logic claimed, output logic [DW-1:0] tail_data);
    claimed = (addr[AW-1:8] == RCP_TAG);
    if (claimed) begin
      if (rd) tail_data = regs.exists(addr) ? regs[addr] : '0;
      else begin
        regs[addr] = wdata;
        tail_data  = wdata;
      end
    end else begin
      tail_data = rd ? '0 : wdata;
    end
  endtask

  // One full access; called at a negedge with busy low, returns at the negedge where busy has fallen.
  task automatic do_access(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int lat, input bit foreign, input bit mid_req);
    logic claimed;
    logic [DW-1:0] tail_data;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_data;
    check("idle_before_req", core_reg_busy, 1'b0);
    core_reg_req     = 1'b1;
    core_reg_rd_wr_L = rd;
    core_reg_addr    = addr;
    core_reg_wr_data = wdata;
    tick();
    core_reg_req     = 1'b0;
    core_reg_rd_wr_L = 1'($urandom);
    core_reg_addr    = AW'($urandom);
    core_reg_wr_data = $urandom;
    check("launch_head", head_bus(), {1'b1, 1'b0, rd, addr, (rd ? 32'h0 : wdata), SW'(SRC)});
    check("launch_busy", core_reg_busy, 1'b1);
    ring_model(rd, addr, wdata, claimed, tail_data);
    exp_q.push_back(claimed ? tail_data : DEAD);
    for (int i = 0; i < lat; i++) begin
      tick();
      if (i == 0) begin
        check("head_one_cycle", head_bus(), 128'h0);
        if (mid_req) begin
          core_reg_req  = 1'b1;
          core_reg_addr = {RCP_TAG, 8'h3c};
        end
      end
      if (i == 1 && mid_req) begin
        core_reg_req = 1'b0;
        check("mid_req_no_launch", reg_req_out, 1'b0);
      end
    end
    if (foreign) begin
      drive_ret(SW'(SRC) ^ 2'b10, 1'b1, 32'h0bad_0bad, addr, rd);
      tick();
      clear_tail();
      check("foreign_dropped_busy", {core_reg_busy, core_reg_ack}, 2'b10);
    end
    drive_ret(SW'(SRC), claimed, tail_data, addr, rd);
    tick();
    clear_tail();
    exp_data = exp_q.pop_front();
    check("ack_pulse", {core_reg_ack, core_reg_busy}, 2'b11);
    check("rd_data", core_reg_rd_data, exp_data);
    check("err", core_reg_err, !claimed);
    tick();
    check("ack_end", {core_reg_ack, core_reg_busy}, 2'b00);
    check("rd_data_hold", {core_reg_err, core_reg_rd_data}, {!claimed, exp_data});
  endtask

  initial begin
    int k;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic r;
    int lat;

    reset = 1'b1;
    core_reg_req = 1'b0;
    core_reg_rd_wr_L = 1'b0;
    core_reg_addr = '0;
    core_reg_wr_data = '0;
    clear_tail();
    repeat (3) tick();
    check("reset_head", head_bus(), 128'h0);
    check("reset_core", {core_reg_busy, core_reg_ack, core_reg_err, core_reg_rd_data}, 35'h0);
    check("reset_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    tick();

    // write then read of the RCP rate register
    do_access(1'b0, {RCP_TAG, 8'h00}, 32'h0000_1234, 2, 1'b0, 1'b0);
    do_access(1'b1, {RCP_TAG, 8'h00}, 32'h0, 1, 1'b0, 1'b0);
    check("rcp_rate_readback", core_reg_rd_data, 32'h0000_1234);

    // unmapped tag loops back unclaimed
    do_access(1'b1, {15'h7ff0, 8'h04}, 32'h0, 3, 1'b0, 1'b0);

    // timeout with tail idle, then a late return that must be ignored
    core_reg_req = 1'b1; core_reg_rd_wr_L = 1'b1; core_reg_addr = {15'h0456, 8'h08};
    tick();
    core_reg_req = 1'b0;
    k = 1;
    while (!core_reg_ack && k < 40) begin
      tick();
      k++;
    end
    check("timeout_latency", k, TOUT + 2);
    check("timeout_result", {core_reg_err, core_reg_rd_data}, {1'b1, DEAD});
    repeat (5) tick();
    drive_ret(SW'(SRC), 1'b1, 32'h1111_2222, {15'h0456, 8'h08}, 1'b1);
    tick();
    clear_tail();
    for (int i = 0; i < 4; i++) begin
      check("late_return_ignored", {core_reg_ack, core_reg_busy}, 2'b00);
      tick();
    end

    // return on the timeout boundary cycle wins
    core_reg_req = 1'b1; core_reg_rd_wr_L = 1'b1; core_reg_addr = {RCP_TAG, 8'h10};
    tick();
    core_reg_req = 1'b0;
    repeat (TOUT) tick();
    check("boundary_no_ack_yet", core_reg_ack, 1'b0);
    drive_ret(SW'(SRC), 1'b1, 32'hA5A5_A5A5, {RCP_TAG, 8'h10}, 1'b1);
    tick();
    clear_tail();
    check("boundary_ack", {core_reg_ack, core_reg_err, core_reg_rd_data}, {2'b10, 32'hA5A5_A5A5});
    tick();
    check("boundary_idle", core_reg_busy, 1'b0);

    // three back-to-back requests, one with a mid-busy req pulse
    do_access(1'b0, {RCP_TAG, 8'h04}, 32'hCAFE_0001, 1, 1'b0, 1'b0);
    do_access(1'b0, {RCP_TAG, 8'h08}, 32'hCAFE_0002, 4, 1'b0, 1'b1);
    do_access(1'b1, {RCP_TAG, 8'h04}, 32'h0, 2, 1'b0, 1'b0);

    // foreign-source return then the real one
    do_access(1'b1, {RCP_TAG, 8'h08}, 32'h0, 2, 1'b1, 1'b0);

    // randomized accesses against the ring model
    for (int n = 0; n < 24; n++) begin
      r   = 1'($urandom);
      a   = {(($urandom_range(0, 3) != 0) ? RCP_TAG : 15'($urandom_range(1, 100) + 32'h200)),
             8'($urandom_range(0, 3) * 4)};
      d   = $urandom;
      lat = $urandom_range(1, 6);
      do_access(r, a, d, lat, ($urandom_range(0, 3) == 0), (lat >= 2) && ($urandom_range(0, 4) == 0));
    end

    // reset during WAIT aborts the access; its return is dropped
    core_reg_req = 1'b1; core_reg_rd_wr_L = 1'b1; core_reg_addr = {RCP_TAG, 8'h00};
    tick();
    core_reg_req = 1'b0;
    repeat (2) tick();
    check("pre_reset_wait", dbg_state, ST_WAIT);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_head", head_bus(), 128'h0);
    check("abort_core", {core_reg_busy, core_reg_ack, core_reg_err, core_reg_rd_data}, 35'h0);
    drive_ret(SW'(SRC), 1'b1, 32'h0000_1234, {RCP_TAG, 8'h00}, 1'b1);
    tick();
    clear_tail();
    for (int i = 0; i < 3; i++) begin
      check("abort_no_ack", {core_reg_ack, core_reg_busy}, 2'b00);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rcp_reg_ring_master.md
# rcp_reg_ring_master

Initiator and terminator of the UDP register ring that the RCP register blocks sit on. It accepts one register access at a time from a simple host-side command port and launches it onto the ring as a single-cycle request. It then collects the request when it returns at the ring tail and hands read data plus an error status back to the host. Each ring responder, including the RCP rate/statistics register block, claims an access by setting ack and, for reads, substituting its data.

## Interface

Clock and reset: reset reset, synchronous, active-high; clock clk.

Parameters:
- UDP_REG_SRC_WIDTH, 2: width of the ring source tag.
- SRC_ID, 0: source tag this master stamps on requests; returns with any other tag are discarded.
- TIMEOUT, 255: cycles to wait for a return after launch before aborting.
- TO_WIDTH, 8: width of the timeout counter; must satisfy 2**TO_WIDTH > TIMEOUT.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous active-high reset.
- core_reg_req, in, 1: one-cycle access request; sampled only when core_reg_busy=0.
- core_reg_rd_wr_L, in, 1: 1=read, 0=write.
- core_reg_addr, in, `UDP_REG_ADDR_WIDTH: full ring address (block tag + register offset).
- core_reg_wr_data, in, `CPCI_NF2_DATA_WIDTH: write data.
- core_reg_busy, out, 1: access in flight.
- core_reg_ack, out, 1: one-cycle completion pulse.
- core_reg_rd_data, out, `CPCI_NF2_DATA_WIDTH: returned data; valid with ack.
- core_reg_err, out, 1: with ack, 1 = unclaimed or timed out.
- reg_req_out, reg_ack_out, reg_rd_wr_L_out, out, 1 each: ring head.
- reg_addr_out, out, `UDP_REG_ADDR_WIDTH: ring head address.
- reg_data_out, out, `CPCI_NF2_DATA_WIDTH: ring head data.
- reg_src_out, out, UDP_REG_SRC_WIDTH: ring head source tag.
- reg_req_in, reg_ack_in, reg_rd_wr_L_in, in, 1 each: ring tail.
- reg_addr_in, in, `UDP_REG_ADDR_WIDTH: ring tail address.
- reg_data_in, in, `CPCI_NF2_DATA_WIDTH: ring tail data.
- reg_src_in, in, UDP_REG_SRC_WIDTH: ring tail source tag.

## Operation

- FSM states:
  - IDLE: busy=0.
  - ISSUE: launch cycle.
  - WAIT: timeout counter runs.
  - DONE: ack cycle.
- IDLE→ISSUE on core_reg_req. The block latches rd_wr_L, addr and wr_data.
- ISSUE drives the ring head for exactly one cycle:
  - reg_req_out=1, reg_ack_out=0, reg_src_out=SRC_ID.
  - addr and rd_wr_L from the latched values.
  - reg_data_out = wr_data for writes, 0 for reads.
- ISSUE→WAIT unconditionally. The timeout counter clears to 0.
- In WAIT, a valid return is reg_req_in=1 with reg_src_in==SRC_ID:
  - ack_in=1: rd_data=reg_data_in, err=0.
  - ack_in=0: rd_data=32'hdead_beef, err=1.
  - Either way WAIT→DONE.
- WAIT with no valid return: the counter increments. When counter==TIMEOUT-1 with no return, rd_data=32'hdead_beef, err=1, WAIT→DONE.
- A valid return in the same cycle as the timeout boundary wins; it is handled as a return.
- DONE: core_reg_ack=1 for one cycle, then DONE→IDLE.
- Ring tail inputs are consumed, never forwarded. Returns in IDLE, ISSUE or DONE, and returns with a foreign src, are dropped silently. A late return after a timeout is therefore discarded.
- core_reg_req while busy=1 is ignored; it is neither queued nor reflected.
- Outside ISSUE, every ring head output is 0.

## Timing

- Reset values: all ring head outputs 0; core_reg_busy=0, core_reg_ack=0, core_reg_rd_data=0, core_reg_err=0; state IDLE; counter 0.
- Reset mid-transaction aborts the transaction with no ack. Any later return of it is dropped.
- All outputs are registered.
- Core req sampled at edge N → reg_req_out high during cycle N+1, busy high from N+1.
- Valid return sampled at edge M → core_reg_ack, rd_data and err high during cycle M+1. busy drops in cycle M+2.
- Timeout with no return: ack occurs TIMEOUT+2 cycles after the request edge.
- Back-to-back: the next core_reg_req is accepted at the edge where busy=0. The minimum period is ring latency + 3 cycles.
- rd_data and err hold their values after ack until the next completion.

## Structure

- Shared defines (common register define file): `UDP_REG_ADDR_WIDTH, `CPCI_NF2_DATA_WIDTH, the dead_beef constant and the FSM state encodings.
- No sub-module is needed. The timeout counter is inline.
- At the top level, the RCP register block sits between reg_*_out and reg_*_in.

## Test plan

- Write, then read:
  - Write addr = `RCP_BLOCK_ADDR:0, data 32'h0000_1234 → ring shows req=1, rd_wr_L=0 for one cycle; responder acks; core_reg_ack with err=0; rcp_rate=32'h1234.
  - Read of the same address → rd_data=32'h1234, err=0.
- Read of an unmapped tag, looped back with ack_in=0 → ack, err=1, rd_data=32'hdead_beef.
- Tail tied to 0, TIMEOUT=16 → ack exactly 18 cycles after the request, err=1, rd_data=32'hdead_beef. A return injected 5 cycles later is ignored: no second ack.
- Return in the same cycle as the timeout boundary with ack_in=1, data 32'hA5A5_A5A5 → err=0, rd_data=32'hA5A5_A5A5.
- Three back-to-back core requests, each pulsed on the cycle busy falls → three acks in order. A req pulsed mid-busy produces no ring traffic.
- Return with src≠SRC_ID while in WAIT → dropped. A subsequent correct-src return completes the access normally.
- Reset asserted in WAIT → outputs go to their reset values; the returning packet produces no ack.
